// File: rtl/mac_seq_ctrl_if.sv
// Command/result handshake bundle between the control source and mac_seq_ctrl.
// Command and result sides both use valid/ready handshakes.
interface mac_seq_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_data;
    logic             cmd_clr;
    logic             cmd_last;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic [CNT_W-1:0] res_cnt;

    modport master (
        output cmd_valid, cmd_data, cmd_clr, cmd_last, res_ready,
        input  cmd_ready, res_valid, res_data, res_cnt
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_clr, cmd_last, res_ready,
        output cmd_ready, res_valid, res_data, res_cnt
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Serialises one 4-byte command onto the MAC byte bus, fires the accumulate and returns the sum on group end.
// Latency 6+RES_LAT cycles per command (+1 with clr); one command in flight, result held until res_ready.
module mac_seq_ctrl #(
    parameter int RES_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    mac_seq_ctrl_if.slave bus,
    output logic          busy,
    output logic [7:0]    mac_in,
    output logic          mac_ld1,
    output logic          mac_ld2,
    output logic          mac_ld3,
    output logic          mac_ld4,
    output logic          mac_ld,
    output logic          mac_clken,
    output logic          mac_rst,
    input  logic [15:0]   mac_out
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_CLR  = 4'd1;
    localparam logic [3:0] S_LD1  = 4'd2;
    localparam logic [3:0] S_LD2  = 4'd3;
    localparam logic [3:0] S_LD3  = 4'd4;
    localparam logic [3:0] S_LD4  = 4'd5;
    localparam logic [3:0] S_FIRE = 4'd6;
    localparam logic [3:0] S_WAIT = 4'd7;
    localparam logic [3:0] S_RESP = 4'd8;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       WAIT_INIT = 4'(RES_LAT - 1);

    logic [3:0]       state_q, state_d;
    logic [31:0]      data_q, data_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       wait_q, wait_d;
    logic [15:0]      res_data_q, res_data_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        res_data_d = res_data_q;
        res_cnt_d  = res_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    data_d  = bus.cmd_data;
                    last_d  = bus.cmd_last;
                    state_d = bus.cmd_clr ? S_CLR : S_LD1;
                end
            end
            S_CLR: begin
                cnt_d   = '0;
                state_d = S_LD1;
            end
            S_LD1: state_d = S_LD2;
            S_LD2: state_d = S_LD3;
            S_LD3: state_d = S_LD4;
            S_LD4: state_d = S_FIRE;
            S_FIRE: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                wait_d  = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // wait_q counts down the remaining MAC latency; zero means mac_out is valid now
                if (wait_q == 4'd0) begin
                    if (last_q) begin
                        res_data_d = mac_out;
                        res_cnt_d  = cnt_q;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            wait_q     <= '0;
            res_data_q <= '0;
            res_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            res_data_q <= res_data_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    always_comb begin
        mac_in    = 8'h00;
        mac_ld1   = 1'b0;
        mac_ld2   = 1'b0;
        mac_ld3   = 1'b0;
        mac_ld4   = 1'b0;
        mac_ld    = 1'b0;
        mac_clken = 1'b0;
        case (state_q)
            S_CLR:  mac_clken = 1'b1;
            S_LD1:  begin mac_clken = 1'b1; mac_ld1 = 1'b1; mac_in = data_q[7:0];   end
            S_LD2:  begin mac_clken = 1'b1; mac_ld2 = 1'b1; mac_in = data_q[15:8];  end
            S_LD3:  begin mac_clken = 1'b1; mac_ld3 = 1'b1; mac_in = data_q[23:16]; end
            S_LD4:  begin mac_clken = 1'b1; mac_ld4 = 1'b1; mac_in = data_q[31:24]; end
            S_FIRE: begin mac_clken = 1'b1; mac_ld  = 1'b1; end
            S_WAIT: mac_clken = 1'b1;
            default: ;
        endcase
    end

    // The MAC shares the block reset so a mid-sequence reset also flushes its partial state
    assign mac_rst       = rst | (state_q == S_CLR);
    assign busy          = (state_q != S_IDLE);
    assign bus.cmd_ready = (state_q == S_IDLE) & ~rst;
    assign bus.res_valid = (state_q == S_RESP);
    assign bus.res_data  = res_data_q;
    assign bus.res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench: drives mac_seq_ctrl against a behavioural MAC and checks strobes, timing and results.
module tb_mac_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: default parameters
    mac_seq_ctrl_if #(.CNT_W(8)) b1 ();
    logic [7:0]  mac_in;
    logic        mac_ld1, mac_ld2, mac_ld3, mac_ld4, mac_ld, mac_clken, mac_rst;
    logic [15:0] mac_out;
    logic        busy;

    mac_seq_ctrl #(.RES_LAT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(b1.slave), .busy(busy),
        .mac_in(mac_in), .mac_ld1(mac_ld1), .mac_ld2(mac_ld2), .mac_ld3(mac_ld3),
        .mac_ld4(mac_ld4), .mac_ld(mac_ld), .mac_clken(mac_clken), .mac_rst(mac_rst),
        .mac_out(mac_out)
    );

    // Behavioural MAC: acc += r1*r2 + r3*r4 on mac_ld
    logic [7:0]  r1, r2, r3, r4;
    logic [15:0] acc;
    always @(posedge clk) begin
        if (mac_rst) begin
            r1 <= 8'h0; r2 <= 8'h0; r3 <= 8'h0; r4 <= 8'h0; acc <= 16'h0;
        end else if (mac_clken) begin
            if (mac_ld1) r1 <= mac_in;
            if (mac_ld2) r2 <= mac_in;
            if (mac_ld3) r3 <= mac_in;
            if (mac_ld4) r4 <= mac_in;
            if (mac_ld)  acc <= acc + 16'(r1 * r2) + 16'(r3 * r4);
        end
    end
    assign mac_out = acc;

    // Second instance: 2-bit counter, latency 1, used for saturation
    mac_seq_ctrl_if #(.CNT_W(2)) b2 ();
    logic [7:0]  mac_in2;
    logic        m2_ld1, m2_ld2, m2_ld3, m2_ld4, m2_ld, m2_clken, m2_rst;
    logic [15:0] mac_out2;
    logic        busy2;
    assign mac_out2 = 16'h0;

    mac_seq_ctrl #(.RES_LAT(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave), .busy(busy2),
        .mac_in(mac_in2), .mac_ld1(m2_ld1), .mac_ld2(m2_ld2), .mac_ld3(m2_ld3),
        .mac_ld4(m2_ld4), .mac_ld(m2_ld), .mac_clken(m2_clken), .mac_rst(m2_rst),
        .mac_out(mac_out2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] strb();
        return {mac_in, mac_rst, mac_ld1, mac_ld2, mac_ld3, mac_ld4, mac_ld, mac_clken};
    endfunction

    // Presents a command from a negedge; returns at the negedge of cycle T+1
    task automatic send1(input logic [31:0] d, input logic c, input logic l);
        int n;
        b1.cmd_data = d; b1.cmd_clr = c; b1.cmd_last = l; b1.cmd_valid = 1'b1;
        n = 0;
        while (!b1.cmd_ready && n < 40) begin @(negedge clk); n++; end
        chk("send_ready", 32'(b1.cmd_ready), 32'd1);
        @(negedge clk);
        b1.cmd_valid = 1'b0;
    endtask

    // Called at the negedge of T+1; lat = k where res_valid first seen at T+k
    task automatic wait_res(output int lat);
        lat = 1;
        while (!b1.res_valid && lat < 60) begin @(negedge clk); lat++; end
        chk("res_valid_seen", 32'(b1.res_valid), 32'd1);
    endtask

    task automatic take_res();
        b1.res_ready = 1'b1;
        @(negedge clk);
        b1.res_ready = 1'b0;
        chk("take_busy", 32'(busy), 32'd0);
        chk("take_ready", 32'(b1.cmd_ready), 32'd1);
    endtask

    logic [14:0] exp_seq [0:8];
    logic [31:0] burst_d [0:2];
    logic        burst_c [0:2];
    logic        burst_l [0:2];
    int          hs [0:2];
    int          lat;
    int          k;
    int          n;

    initial begin
        b1.cmd_valid = 1'b0; b1.cmd_data = '0; b1.cmd_clr = 1'b0; b1.cmd_last = 1'b0; b1.res_ready = 1'b0;
        b2.cmd_valid = 1'b0; b2.cmd_data = '0; b2.cmd_clr = 1'b0; b2.cmd_last = 1'b0; b2.res_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(b1.cmd_ready), 32'd0);
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_res_valid", 32'(b1.res_valid), 32'd0);
        chk("rst_res_data",  32'(b1.res_data),  32'd0);
        chk("rst_res_cnt",   32'(b1.res_cnt),   32'd0);
        chk("rst_strobes",   32'(strb()),       32'h0040);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(b1.cmd_ready), 32'd1);

        // Single op with clr: per-cycle strobe pattern T+1..T+9
        exp_seq[0] = {8'h00, 7'b1000001};
        exp_seq[1] = {8'h01, 7'b0100001};
        exp_seq[2] = {8'h02, 7'b0010001};
        exp_seq[3] = {8'h03, 7'b0001001};
        exp_seq[4] = {8'h04, 7'b0000101};
        exp_seq[5] = {8'h00, 7'b0000011};
        exp_seq[6] = {8'h00, 7'b0000001};
        exp_seq[7] = {8'h00, 7'b0000001};
        exp_seq[8] = {8'h00, 7'b0000000};
        send1(32'h04030201, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("single_strb_T%0d", i + 1), 32'(strb()), 32'(exp_seq[i]));
            chk($sformatf("single_valid_T%0d", i + 1), 32'(b1.res_valid), (i == 8) ? 32'd1 : 32'd0);
            if (i < 8) @(negedge clk);
        end
        chk("single_data", 32'(b1.res_data), 32'h000E);
        chk("single_cnt",  32'(b1.res_cnt),  32'd1);

        // Backpressure: result held, commands refused
        b1.cmd_valid = 1'b1; b1.cmd_data = 32'hFFFFFFFF; b1.cmd_clr = 1'b1; b1.cmd_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(b1.res_valid), 32'd1);
            chk("bp_data",  32'(b1.res_data),  32'h000E);
            chk("bp_cnt",   32'(b1.res_cnt),   32'd1);
            chk("bp_ready", 32'(b1.cmd_ready), 32'd0);
        end
        b1.cmd_valid = 1'b0;
        take_res();

        // Continuation without clr
        send1(32'h04030201, 1'b0, 1'b1);
        wait_res(lat);
        chk("cont_lat",  32'(lat),          32'd8);
        chk("cont_data", 32'(b1.res_data),  32'h001C);
        chk("cont_cnt",  32'(b1.res_cnt),   32'd1);
        take_res();

        // Burst of three with cmd_valid held high
        burst_d[0] = 32'h01010101; burst_c[0] = 1'b1; burst_l[0] = 1'b0;
        burst_d[1] = 32'h02020202; burst_c[1] = 1'b0; burst_l[1] = 1'b0;
        burst_d[2] = 32'h03030303; burst_c[2] = 1'b0; burst_l[2] = 1'b1;
        k = 0;
        b1.cmd_data = burst_d[0]; b1.cmd_clr = burst_c[0]; b1.cmd_last = burst_l[0]; b1.cmd_valid = 1'b1;
        for (int i = 0; i < 80 && k < 3; i++) begin
            if (b1.cmd_ready) begin
                hs[k] = cyc;
                k++;
                @(negedge clk);
                if (k < 3) begin
                    b1.cmd_data = burst_d[k]; b1.cmd_clr = burst_c[k]; b1.cmd_last = burst_l[k];
                end else begin
                    b1.cmd_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
        b1.cmd_valid = 1'b0;
        chk("burst_accepted", 32'(k), 32'd3);
        chk("burst_gap01", 32'(hs[1] - hs[0]), 32'd9);
        chk("burst_gap12", 32'(hs[2] - hs[1]), 32'd8);
        wait_res(lat);
        chk("burst_data", 32'(b1.res_data), 32'h001C);
        chk("burst_cnt",  32'(b1.res_cnt),  32'd3);
        take_res();

        // Reset during LD3
        send1(32'h04030201, 1'b1, 1'b1);
        n = 0;
        while (!mac_ld3 && n < 20) begin @(negedge clk); n++; end
        chk("mid_saw_ld3", 32'(mac_ld3), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_strb",      32'(strb()),       32'h0040);
        chk("mid_busy",      32'(busy),         32'd0);
        chk("mid_cmd_ready", 32'(b1.cmd_ready), 32'd0);
        chk("mid_res_valid", 32'(b1.res_valid), 32'd0);
        chk("mid_res_data",  32'(b1.res_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_release_ready", 32'(b1.cmd_ready), 32'd1);
        send1(32'h04030201, 1'b1, 1'b1);
        wait_res(lat);
        chk("after_rst_lat",  32'(lat),         32'd9);
        chk("after_rst_data", 32'(b1.res_data), 32'h000E);
        chk("after_rst_cnt",  32'(b1.res_cnt),  32'd1);
        take_res();

        // Saturation on the 2-bit counter instance, RES_LAT=1
        for (int c = 0; c < 5; c++) begin
            b2.cmd_data = 32'h01010101; b2.cmd_clr = 1'b0; b2.cmd_last = (c == 4); b2.cmd_valid = 1'b1;
            n = 0;
            while (!b2.cmd_ready && n < 40) begin @(negedge clk); n++; end
            chk("sat_ready", 32'(b2.cmd_ready), 32'd1);
            @(negedge clk);
            b2.cmd_valid = 1'b0;
        end
        lat = 1;
        while (!b2.res_valid && lat < 60) begin @(negedge clk); lat++; end
        chk("sat_valid", 32'(b2.res_valid), 32'd1);
        chk("sat_lat",   32'(lat),          32'd7);
        chk("sat_cnt",   32'(b2.res_cnt),   32'd3);
        b2.res_ready = 1'b1;
        @(negedge clk);
        b2.res_ready = 1'b0;
        chk("sat_idle", 32'(busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
